iot_feed_sched: RTL and testbench



---
 rtl/iot_feed_sched.sv | 210 +++++++++++++++++++++
 tb/tb_iot_feed_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iot_feed_sched.sv
// iot_feed_sched: shares one IOTDF engine between NREQ sensor requesters.
// Each requester is granted a whole round of SPR 128-bit samples in round-robin
// order. Samples are staged in a hold register, then serialized MSB byte first
// through a shift register onto iot_in/in_en. Rounds are arbitrated ahead of
// time so that consecutive rounds abut without an idle cycle.
module iot_feed_sched #(
    parameter int NREQ = 4,
    parameter int SPR  = 8,
    parameter int BPS  = 16,
    localparam int OWW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW  = $clog2(SPR + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_en,
    input  logic [2:0]          cfg_fn,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*128-1:0] req_data,
    output logic [NREQ-1:0]     req_ready,
    input  logic                dut_busy,
    output logic                in_en,
    output logic [7:0]          iot_in,
    output logic [2:0]          fn_sel,
    output logic [OWW-1:0]      round_owner,
    output logic                round_done,
    output logic                underrun
);

    localparam logic [3:0]    LAST_BYTE = 4'(BPS - 1);
    localparam logic [CW-1:0] SPR_FULL  = CW'(SPR);
    localparam logic [CW-1:0] SPR_LAST  = CW'(SPR - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state;

    // Accept side: who may hand over samples and how many it has delivered.
    logic [OWW-1:0] acc_owner;
    logic [CW-1:0]  acc_cnt;
    logic [OWW-1:0] rr_ptr;

    // Hold register: one staged sample, tagged with its owner and whether it
    // closes the round.
    logic [127:0]   hold;
    logic           hold_full;
    logic [OWW-1:0] hold_owner;
    logic           hold_last;

    // Shift register: the sample currently being serialized.
    logic [127:0]   sh;
    logic           sh_full;
    logic           sh_last;
    logic [3:0]     byte_cnt;

    logic           shift_step;
    logic           wrap;
    logic           hold_move;
    logic           acc_open;
    logic           xfer;
    logic [127:0]   acc_data;

    logic           arb_found;
    logic [OWW-1:0] arb_winner;
    int             arb_best;
    int             arb_dist;

    // Round-robin search: pick the valid requester closest after rr_ptr.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned and no latch is inferred.
        arb_found  = 1'b0;
        arb_winner = '0;
        arb_best   = NREQ;
        arb_dist   = 0;
        for (int i = 0; i < NREQ; i++) begin
            // Distance 0 is the requester right after the pointer.
            arb_dist = (i + NREQ - 1 - int'(rr_ptr)) % NREQ;
            if (req_valid[i] && (arb_dist < arb_best)) begin
                arb_best   = arb_dist;
                arb_winner = OWW'(i);
                arb_found  = 1'b1;
            end
        end
    end

    // Stream strobes, hold-to-shift movement and the accept handshake.
    always_comb begin
        shift_step = sh_full & ~dut_busy;
        wrap       = shift_step & (byte_cnt == LAST_BYTE);
        // Hold empties either at a sample boundary or into an idle shifter.
        hold_move  = hold_full & (~sh_full | wrap);
        acc_open   = (state == RUN) & (~hold_full | hold_move) & (acc_cnt < SPR_FULL);

        req_ready = '0;
        if (acc_open) begin
            req_ready[acc_owner] = 1'b1;
        end
        xfer = |(req_valid & req_ready);

        acc_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_owner == OWW'(i)) begin
                acc_data = req_data[i*128 +: 128];
            end
        end

        in_en      = shift_step;
        iot_in     = sh[127:120];
        round_done = wrap & sh_last;
        // The final byte of a drained session is an intentional end of stream,
        // not a starved boundary, so it does not count as an underrun.
        underrun   = wrap & ~hold_full & (state != DRAIN);
    end

    // Session FSM: arbitration, accept counting and function select capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fn_sel    <= '0;
            acc_owner <= '0;
            acc_cnt   <= '0;
            rr_ptr    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            unique case (state)
                IDLE: begin
                    if (cfg_en && arb_found) begin
                        state     <= RUN;
                        fn_sel    <= cfg_fn;
                        acc_owner <= arb_winner;
                        acc_cnt   <= '0;
                        rr_ptr    <= arb_winner;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        acc_cnt <= acc_cnt + 1'b1;
                    end else if (acc_cnt == SPR_FULL) begin
                        // Lookahead: the next round is granted while the
                        // current one is still streaming out of hold/sh.
                        if (!cfg_en) begin
                            state <= DRAIN;
                        end else if (arb_found) begin
                            acc_owner <= arb_winner;
                            acc_cnt   <= '0;
                            rr_ptr    <= arb_winner;
                        end
                    end
                end
                DRAIN: begin
                    // The pipeline may already be empty if the last round
                    // finished while RUN was waiting for a requester.
                    if (round_done || (!sh_full && !hold_full)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: stage accepted samples in hold and serialize them from sh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the wide hold and shift registers are reset because iot_in
            // is driven straight from sh and must read 0 after reset.
            hold        <= '0;
            hold_full   <= 1'b0;
            hold_owner  <= '0;
            hold_last   <= 1'b0;
            sh          <= '0;
            sh_full     <= 1'b0;
            sh_last     <= 1'b0;
            byte_cnt    <= '0;
            round_owner <= '0;
        end else begin
            // A new transfer may land in the same cycle hold moves to sh.
            if (xfer) begin
                hold       <= acc_data;
                hold_full  <= 1'b1;
                hold_owner <= acc_owner;
                hold_last  <= (acc_cnt == SPR_LAST);
            end else if (hold_move) begin
                hold_full <= 1'b0;
            end

            if (hold_move) begin
                sh          <= hold;
                sh_full     <= 1'b1;
                sh_last     <= hold_last;
                round_owner <= hold_owner;
                byte_cnt    <= '0;
            end else if (shift_step) begin
                sh <= {sh[119:0], 8'h00};
                if (wrap) begin
                    sh_full  <= 1'b0;
                    byte_cnt <= '0;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iot_feed_sched.sv
// Testbench for iot_feed_sched: per-requester sample generators feed the DUT,
// every accepted sample is expanded into its 16 expected bytes on a scoreboard
// queue, and the byte stream is popped and compared as IOTDF would receive it.
module tb_iot_feed_sched;

    localparam int NREQ = 4;
    localparam int SPR  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_en;
    logic [2:0]          cfg_fn;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*128-1:0] req_data;
    logic [NREQ-1:0]     req_ready;
    logic                dut_busy;
    logic                in_en;
    logic [7:0]          iot_in;
    logic [2:0]          fn_sel;
    logic [1:0]          round_owner;
    logic                round_done;
    logic                underrun;

    iot_feed_sched #(.NREQ(NREQ), .SPR(SPR), .BPS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_en      (cfg_en),
        .cfg_fn      (cfg_fn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .dut_busy    (dut_busy),
        .in_en       (in_en),
        .iot_in      (iot_in),
        .fn_sel      (fn_sel),
        .round_owner (round_owner),
        .round_done  (round_done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         own;
        bit         last;
    } exp_t;

    exp_t exp_q[$];
    int   owner_log[$];
    int   gap_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Generator state per requester.
    int           remaining[NREQ] = '{default: 0};
    int           sent[NREQ]      = '{default: 0};
    int           delay[NREQ]     = '{default: 0};
    int           pause_idx[NREQ] = '{default: -1};
    int           pause_len[NREQ] = '{default: 0};
    bit           took[NREQ]      = '{default: 1'b0};
    logic [127:0] cur_data[NREQ];

    // Monitor state.
    int   exp_fn          = 0;
    int   round_bytes     = 0;
    int   done_cnt        = 0;
    int   under_cnt       = 0;
    int   in_round_gap    = 0;
    int   idle_since_done = 0;
    int   spurious_done   = 0;
    int   onehot_viol     = 0;
    int   xfer_cnt        = 0;
    int   xfer_tot        = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Generators: present a new sample after each accepted one, with an
    // optional pause before a chosen sample index.
    initial begin : driver
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) cur_data[i] = rand128();
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (took[i]) begin
                    took[i] = 1'b0;
                    remaining[i]--;
                    sent[i]++;
                    cur_data[i] = rand128();
                    if (sent[i] == pause_idx[i]) delay[i] = pause_len[i];
                end else if (delay[i] > 0) begin
                    delay[i]--;
                end
                req_valid[i] = (remaining[i] > 0) && (delay[i] == 0);
                req_data[i*128 +: 128] = cur_data[i];
            end
        end
    end

    // Monitor: push expectations on handshakes, pop and compare on in_en.
    initial begin : monitor
        exp_t e;
        exp_t got_e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if ($countones(req_ready) > 1) onehot_viol++;
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        for (int b = 15; b >= 0; b--) begin
                            e.b    = cur_data[i][b*8 +: 8];
                            e.own  = i;
                            e.last = (b == 0) && ((xfer_cnt % SPR) == SPR - 1);
                            exp_q.push_back(e);
                        end
                        xfer_cnt++;
                        xfer_tot++;
                        took[i] = 1'b1;
                    end
                end
                if (underrun) under_cnt++;
                if (in_en) begin
                    if (round_bytes == 0) gap_q.push_back(idle_since_done);
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_byte", 32'(iot_in), 32'hFFFF_FFFF);
                    end else begin
                        got_e = exp_q.pop_front();
                        check("byte", 32'(iot_in), 32'(got_e.b));
                        check("owner", 32'(round_owner), got_e.own);
                        check("round_done", 32'(round_done), 32'(got_e.last));
                        check("fn_sel", 32'(fn_sel), exp_fn);
                    end
                    round_bytes++;
                    if (round_done) begin
                        check("round_bytes", round_bytes, 128);
                        round_bytes = 0;
                        owner_log.push_back(int'(round_owner));
                        done_cnt++;
                        idle_since_done = 0;
                    end
                end else begin
                    idle_since_done++;
                    if (round_bytes > 0) in_round_gap++;
                    if (round_done) spurious_done++;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt < target) check({tag, "_timeout"}, done_cnt, target);
    endtask

    task automatic wait_bytes(input int target, input int budget, input string tag);
        int n = 0;
        while (round_bytes < target && n < budget) begin
            tick();
            n++;
        end
        if (round_bytes < target) check({tag, "_timeout"}, round_bytes, target);
    endtask

    task automatic idle_check(input int cycles, input string tag);
        int viol = 0;
        repeat (cycles) begin
            tick();
            if (in_en || (req_ready != '0)) viol++;
        end
        check(tag, viol, 0);
    endtask

    task automatic start_cfg(input logic [2:0] fn);
        @(posedge clk);
        #1;
        cfg_fn = fn;
        exp_fn = int'(fn);
        cfg_en = 1'b1;
    endtask

    task automatic stop_cfg();
        @(posedge clk);
        #1;
        cfg_en = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int u0;
        int d0;
        int o0;
        int g0;
        int x0;
        int exp_own[5];

        rst      = 1'b1;
        cfg_en   = 1'b0;
        cfg_fn   = 3'd0;
        dut_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_en", 32'(in_en), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_iot_in", 32'(iot_in), 0);
        check("rst_fn_sel", 32'(fn_sel), 0);
        check("rst_owner", 32'(round_owner), 0);
        check("rst_done", 32'(round_done), 0);
        check("rst_underrun", 32'(underrun), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single requester, one full round, cfg_fn changes ignored mid-session.
        u0 = under_cnt;
        d0 = done_cnt;
        in_round_gap = 0;
        remaining[0] = 8;
        start_cfg(3'd3);
        wait_bytes(1, 50, "t2_start");
        stop_cfg();
        cfg_fn = 3'd5;
        wait_done(d0 + 1, 400, "t2_done");
        check("t2_in_round_gap", in_round_gap, 0);
        check("t2_underrun", under_cnt - u0, 0);
        idle_check(20, "t2_idle");
        check("t2_fn_hold", 32'(fn_sel), 3);

        // All requesters valid: rotating owners, rounds abut.
        u0 = under_cnt;
        d0 = done_cnt;
        o0 = owner_log.size();
        g0 = gap_q.size();
        for (int i = 0; i < NREQ; i++) remaining[i] = 1000;
        start_cfg(3'd6);
        wait_done(d0 + 4, 1000, "t3_four");
        stop_cfg();
        wait_done(d0 + 5, 400, "t3_five");
        idle_check(20, "t3_idle");
        for (int i = 0; i < NREQ; i++) remaining[i] = 0;
        exp_own = '{1, 2, 3, 0, 1};
        check("t3_rounds", owner_log.size() - o0, 5);
        for (int k = 0; k < 5; k++) begin
            if (o0 + k < owner_log.size()) check($sformatf("t3_owner%0d", k), owner_log[o0 + k], exp_own[k]);
        end
        for (int k = 1; k < 5; k++) begin
            if (g0 + k < gap_q.size()) check($sformatf("t3_gap%0d", k), gap_q[g0 + k], 0);
        end
        check("t3_underrun", under_cnt - u0, 0);

        // Requester withholds sample 3: one underrun, round still 128 bytes.
        u0 = under_cnt;
        d0 = done_cnt;
        in_round_gap = 0;
        sent[0] = 0;
        pause_idx[0] = 3;
        pause_len[0] = 40;
        remaining[0] = 8;
        start_cfg(3'd1);
        wait_bytes(1, 50, "t4_start");
        stop_cfg();
        wait_done(d0 + 1, 600, "t4_done");
        pause_idx[0] = -1;
        check("t4_underrun", under_cnt - u0, 1);
        check("t4_gap_ge5", 32'(in_round_gap >= 5), 1);
        idle_check(10, "t4_idle");

        // dut_busy for 3 cycles mid-sample: byte held, nothing lost.
        u0 = under_cnt;
        d0 = done_cnt;
        remaining[0] = 8;
        start_cfg(3'd4);
        wait_bytes(1, 50, "t5_start");
        stop_cfg();
        wait_bytes(20, 100, "t5_mid");
        @(posedge clk);
        #1;
        dut_busy = 1'b1;
        repeat (3) begin
            tick();
            check("t5_busy_in_en", 32'(in_en), 0);
            if (exp_q.size() > 0) check("t5_busy_iot_in", 32'(iot_in), 32'(exp_q[0].b));
            else check("t5_busy_sb", 0, 1);
        end
        @(posedge clk);
        #1;
        dut_busy = 1'b0;
        wait_done(d0 + 1, 400, "t5_done");
        check("t5_underrun", under_cnt - u0, 0);
        idle_check(10, "t5_idle");

        // cfg_en dropped during sample 2: the round completes, then idle.
        u0 = under_cnt;
        d0 = done_cnt;
        x0 = xfer_tot;
        remaining[1] = 20;
        start_cfg(3'd2);
        wait_bytes(40, 200, "t6_mid");
        stop_cfg();
        wait_done(d0 + 1, 400, "t6_done");
        idle_check(30, "t6_idle");
        check("t6_samples", xfer_tot - x0, 8);
        check("t6_underrun", under_cnt - u0, 0);
        remaining[1] = 0;
        check("sb_drained", exp_q.size(), 0);

        // Reset in the middle of a streaming round.
        remaining[2] = 50;
        start_cfg(3'd7);
        wait_bytes(5, 100, "t1_start");
        rst = 1'b1;
        #1;
        check("t1_in_en", 32'(in_en), 0);
        check("t1_ready", 32'(req_ready), 0);
        check("t1_done", 32'(round_done), 0);
        check("t1_underrun", 32'(underrun), 0);
        check("t1_fn_sel", 32'(fn_sel), 0);
        cfg_en = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) took[i] = 1'b0;
        round_bytes = 0;
        xfer_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_check(15, "t1_idle_after_rst");
        remaining[2] = 0;

        check("ready_onehot", onehot_viol, 0);
        check("spurious_done", spurious_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
